// File: rtl/bsg_fifos_to_axil.sv
// bsg_fifos_to_axil: AXI-Lite manager driven by a request FIFO; each write response or read data
// becomes one response FIFO entry. Define BSG_FIFOS_TO_AXIL_PERF_EN for completed write/read counters.

module bsg_fifos_to_axil_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic               enq,
  input  logic [width_p-1:0] enq_data,
  output logic               valid,
  output logic [width_p-1:0] deq_data,
  input  logic               deq
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w-1:0]   count;
  logic               do_enq, do_deq;

  assign ready    = (count != cnt_w'(els_p));
  assign valid    = (count != '0);
  assign deq_data = mem[rd_ptr];
  assign do_enq   = enq & ready;
  assign do_deq   = deq & valid;

  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      count <= count + cnt_w'(do_enq) - cnt_w'(do_deq);
    end
  end
endmodule

module bsg_fifos_to_axil #(
  parameter  int req_els_p = 4,
  parameter  int rsp_els_p = 2,
  localparam int axil_mosi_bus_width_lp = 111,
  localparam int axil_miso_bus_width_lp = 41
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              req_v_i,
  output logic                              req_ready_o,
  input  logic                              req_we_i,
  input  logic [31:0]                       req_addr_i,
  input  logic [31:0]                       req_data_i,
  input  logic [3:0]                        req_wstrb_i,
  output logic                              rsp_v_o,
  input  logic                              rsp_yumi_i,
  output logic                              rsp_we_o,
  output logic [31:0]                       rsp_data_o,
  output logic [1:0]                        rsp_resp_o,
  output logic [axil_mosi_bus_width_lp-1:0] m_axil_bus_o,
  input  logic [axil_miso_bus_width_lp-1:0] m_axil_bus_i,
  output logic [31:0]                       wr_count_o,
  output logic [31:0]                       rd_count_o
);
  localparam logic [2:0] E_IDLE    = 3'd0;
  localparam logic [2:0] E_WR      = 3'd1;
  localparam logic [2:0] E_WR_RESP = 3'd2;
  localparam logic [2:0] E_RD      = 3'd3;
  localparam logic [2:0] E_RD_DATA = 3'd4;

  logic [2:0]  state_r, state_n;
  logic        aw_done_r, w_done_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  wstrb_r;

  logic        req_fifo_v, pop;
  logic [68:0] req_fifo_data;

  bsg_fifos_to_axil_fifo #(.width_p(69), .els_p(req_els_p)) req_fifo (
    .clk(clk_i), .reset(reset_i), .ready(req_ready_o), .enq(req_v_i),
    .enq_data({req_we_i, req_addr_i, req_data_i, req_wstrb_i}),
    .valid(req_fifo_v), .deq_data(req_fifo_data), .deq(pop)
  );

  // Bundles use the bsg field order: mosi {aw, w, bready, ar, rready}, miso {awready, wready, b, arready, r}.
  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high; a
  // raised valid holds its payload until that edge.
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awvalid, wvalid, bready, arvalid, rready;

  assign {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid} = m_axil_bus_i;

  assign awvalid = (state_r == E_WR) & ~aw_done_r;
  assign wvalid  = (state_r == E_WR) & ~w_done_r;
  assign bready  = (state_r == E_WR_RESP);
  assign arvalid = (state_r == E_RD);
  assign rready  = (state_r == E_RD_DATA);

  assign m_axil_bus_o = {addr_r, 3'b000, awvalid, wdata_r, wstrb_r, wvalid, bready,
                         addr_r, 3'b000, arvalid, rready};

  logic aw_done_n, w_done_n, wr_both;
  assign aw_done_n = aw_done_r | (awvalid & awready);
  assign w_done_n  = w_done_r  | (wvalid & wready);
  assign wr_both   = aw_done_n & w_done_n;

  logic        b_hs, r_hs, rsp_enq, rsp_fifo_ready;
  logic [34:0] rsp_entry;
  assign b_hs      = bready & bvalid;
  assign r_hs      = rready & rvalid;
  assign rsp_enq   = b_hs | r_hs;
  assign rsp_entry = b_hs ? {1'b1, bresp, 32'h0} : {1'b0, rresp, rdata};

  // A pop requires response space and only one transaction is in flight, so rsp_enq never meets a full FIFO.
  bsg_fifos_to_axil_fifo #(.width_p(35), .els_p(rsp_els_p)) rsp_fifo (
    .clk(clk_i), .reset(reset_i), .ready(rsp_fifo_ready), .enq(rsp_enq),
    .enq_data(rsp_entry), .valid(rsp_v_o),
    .deq_data({rsp_we_o, rsp_resp_o, rsp_data_o}), .deq(rsp_yumi_i)
  );

  always_comb begin
    state_n = state_r;
    pop     = 1'b0;
    case (state_r)
      E_IDLE: begin
        if (req_fifo_v & rsp_fifo_ready) begin
          pop     = 1'b1;
          state_n = req_fifo_data[68] ? E_WR : E_RD;
        end
      end
      E_WR:      if (wr_both) state_n = E_WR_RESP;
      E_WR_RESP: if (bvalid)  state_n = E_IDLE;
      E_RD:      if (arready) state_n = E_RD_DATA;
      E_RD_DATA: if (rvalid)  state_n = E_IDLE;
      default:   state_n = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= E_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == E_WR) begin
        aw_done_r <= wr_both ? 1'b0 : aw_done_n;
        w_done_r  <= wr_both ? 1'b0 : w_done_n;
      end
      if (pop) begin
        addr_r  <= req_fifo_data[67:36];
        wdata_r <= req_fifo_data[35:4];
        wstrb_r <= req_fifo_data[3:0];
      end
    end
  end

`ifdef BSG_FIFOS_TO_AXIL_PERF_EN
  logic [31:0] wr_count_r, rd_count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_count_r <= '0;
      rd_count_r <= '0;
    end else begin
      if (b_hs) wr_count_r <= wr_count_r + 32'd1;
      if (r_hs) rd_count_r <= rd_count_r + 32'd1;
    end
  end

  assign wr_count_o = wr_count_r;
  assign rd_count_o = rd_count_r;
`else
  assign wr_count_o = 32'h0;
  assign rd_count_o = 32'h0;
`endif
endmodule

// File: tb/tb_bsg_fifos_to_axil.sv
// Directed bench for bsg_fifos_to_axil: a subordinate model answers AXI-Lite traffic and a
// response monitor checks every response FIFO entry against a queue filled at request time.
`timescale 1ns/1ps
module tb_bsg_fifos_to_axil;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i;
  logic         req_v_i, req_ready_o, req_we_i;
  logic [31:0]  req_addr_i, req_data_i;
  logic [3:0]   req_wstrb_i;
  logic         rsp_v_o, rsp_yumi_i, rsp_we_o;
  logic [31:0]  rsp_data_o;
  logic [1:0]   rsp_resp_o;
  logic [110:0] mosi;
  logic [40:0]  miso;
  logic [31:0]  wr_count_o, rd_count_o;

  bsg_fifos_to_axil #(.req_els_p(4), .rsp_els_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_wstrb_i(req_wstrb_i),
    .rsp_v_o(rsp_v_o), .rsp_yumi_i(rsp_yumi_i), .rsp_we_o(rsp_we_o),
    .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o),
    .m_axil_bus_o(mosi), .m_axil_bus_i(miso),
    .wr_count_o(wr_count_o), .rd_count_o(rd_count_o)
  );

  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  assign {awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready} = mosi;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  assign miso = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [34:0] exp_q[$];     // {we, resp, data}
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];   // {wdata, wstrb}
  logic [31:0] exp_ar_q[$];
  logic [1:0]  b_cfg_q[$];
  logic [33:0] r_cfg_q[$];   // {rresp, rdata}

  int   aw_delay = 0, w_delay = 0;
  logic ar_block = 1'b0, rsp_hold = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, mon_wr = 0, mon_rd = 0;

  int          aw_wait, w_wait;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [1:0]  b_resp_l;
  logic [33:0] r_l;
  logic [34:0] mon_e;

  // Subordinate model: readies are decided at the falling edge, so valid&ready here means a transfer at the next rise.
  always @(negedge clk) begin
    if (reset_i) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      b_resp_l = 0; r_l = 0;
    end else begin
      bvalid = b_pend;
      bresp  = b_pend ? b_resp_l : 2'b00;
      if (b_pend && bready) b_pend = 0;
      rvalid = r_pend;
      {rresp, rdata} = r_pend ? r_l : 34'h0;
      if (r_pend && rready) r_pend = 0;

      awready = 0;
      if (aw_got) chk("awvalid_drop", awvalid, 0);
      else if (awvalid) begin
        if (aw_wait >= aw_delay) begin
          awready = 1; aw_wait = 0; aw_got = 1; aw_cnt++;
          chk("awprot", awprot, 0);
          if (exp_aw_q.size() == 0) begin total++; bad++; $display("FAIL aw_unexpected: addr %0h", awaddr); end
          else chk("awaddr", awaddr, exp_aw_q.pop_front());
        end else aw_wait++;
      end

      wready = 0;
      if (w_got) chk("wvalid_drop", wvalid, 0);
      else if (wvalid) begin
        if (exp_w_q.size() == 0) begin total++; bad++; $display("FAIL w_unexpected: data %0h", wdata); end
        else if (w_wait >= w_delay) begin
          wready = 1; w_wait = 0; w_got = 1; w_cnt++;
          chk("w_beat", {wdata, wstrb}, exp_w_q.pop_front());
        end else begin
          w_wait++;
          chk("w_stable", {wdata, wstrb}, exp_w_q[0]);
        end
      end

      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1;
        if (b_cfg_q.size() != 0) b_resp_l = b_cfg_q.pop_front();
        else b_resp_l = 2'b00;
      end

      arready = 0;
      if (arvalid && !ar_block) begin
        arready = 1; r_pend = 1; ar_cnt++;
        chk("arprot", arprot, 0);
        if (r_cfg_q.size() != 0) r_l = r_cfg_q.pop_front();
        else r_l = 34'h0;
        if (exp_ar_q.size() == 0) begin total++; bad++; $display("FAIL ar_unexpected: addr %0h", araddr); end
        else chk("araddr", araddr, exp_ar_q.pop_front());
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (reset_i) rsp_yumi_i = 0;
    else if (rsp_v_o && !rsp_hold) begin
      rsp_yumi_i = 1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got %0h", {rsp_we_o, rsp_resp_o, rsp_data_o});
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", {rsp_we_o, rsp_resp_o, rsp_data_o}, mon_e);
        if (mon_e[34]) mon_wr++;
        else mon_rd++;
      end
    end else rsp_yumi_i = 0;
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
    if (!req_ready_o) begin
      chk("req_ready_wait", req_ready_o, 1);
      return;
    end
    req_v_i = 1; req_we_i = we; req_addr_i = addr; req_data_i = data; req_wstrb_i = strb;
    if (we) begin
      exp_q.push_back({1'b1, resp, 32'h0});
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({data, strb});
      b_cfg_q.push_back(resp);
    end else begin
      exp_q.push_back({1'b0, resp, rd});
      exp_ar_q.push_back(addr);
      r_cfg_q.push_back({resp, rd});
    end
    @(negedge clk);
    req_v_i = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_v_o) && n < 300) begin @(negedge clk); n++; end
    chk({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic chk_counts(input string name);
`ifdef BSG_FIFOS_TO_AXIL_PERF_EN
    chk({name, "_wr_count"}, wr_count_o, mon_wr);
    chk({name, "_rd_count"}, rd_count_o, mon_rd);
`else
    chk({name, "_wr_count"}, wr_count_o, 0);
    chk({name, "_rd_count"}, rd_count_o, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0, ar0, wr0, n;
    reset_i = 1; req_v_i = 0; req_we_i = 0; req_addr_i = 0; req_data_i = 0; req_wstrb_i = 0;
    repeat (3) @(negedge clk);
    reset_i = 0;
    @(negedge clk);
    chk("reset_req_ready", req_ready_o, 1);
    chk("reset_rsp_v", rsp_v_o, 0);
    chk("reset_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("reset_counts", {wr_count_o, rd_count_o}, 0);

    // Write with aw and w accepted together
    aw0 = aw_cnt; w0 = w_cnt;
    send(1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0);
    wait_drain("wr_same");
    chk("wr_same_aw_beats", aw_cnt - aw0, 1);
    chk("wr_same_w_beats", w_cnt - w0, 1);
    chk_counts("wr_same");

    // Split handshake: wready three cycles after awready; non-OKAY bresp passes through
    w_delay = 3; aw0 = aw_cnt; w0 = w_cnt; wr0 = mon_wr;
    send(1, 32'h0000_0020, 32'h1234_5678, 4'h3, 2'b11, 32'h0);
    wait_drain("wr_split");
    chk("wr_split_aw_beats", aw_cnt - aw0, 1);
    chk("wr_split_w_beats", w_cnt - w0, 1);
    chk("wr_split_b_rsps", mon_wr - wr0, 1);
    w_delay = 0;

    // Read with SLVERR
    send(0, 32'h0000_001C, 32'h0, 4'h0, 2'b10, 32'h0000_0004);
    wait_drain("rd");
    chk_counts("rd");

    // Response backpressure: only two reads fit before the response FIFO stalls the pop
    rsp_hold = 1; ar0 = ar_cnt;
    for (int i = 0; i < 4; i++)
      send(0, 32'h0000_0100 + 32'(i * 4), 32'h0, 4'h0, 2'b00, 32'h0000_00A0 + 32'(i));
    repeat (20) @(negedge clk);
    chk("bp_ar_stalled", ar_cnt - ar0, 2);
    chk("bp_rsp_v", rsp_v_o, 1);
    rsp_hold = 0;
    wait_drain("bp");
    chk("bp_ar_total", ar_cnt - ar0, 4);
    chk_counts("bp");

    // Full request FIFO: one read stuck in flight plus four buffered
    ar_block = 1; ar0 = ar_cnt;
    for (int i = 0; i < 5; i++)
      send(0, 32'h0000_0200 + 32'(i * 4), 32'h0, 4'h0, 2'b00, 32'h0000_0B00 + 32'(i));
    @(negedge clk);
    chk("full_req_ready", req_ready_o, 0);
    req_v_i = 1; req_we_i = 0; req_addr_i = 32'h0000_0300;
    @(negedge clk);
    req_v_i = 0;
    repeat (3) @(negedge clk);
    ar_block = 0;
    wait_drain("full");
    chk("full_ar_total", ar_cnt - ar0, 5);
    chk_counts("full");

    // Reset while a write is waiting in E_WR
    aw_delay = 1000; w_delay = 1000;
    send(1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0);
    n = 0;
    while (!awvalid && n < 20) begin @(negedge clk); n++; end
    chk("mid_wr_awvalid", awvalid, 1);
    reset_i = 1;
    @(negedge clk);
    chk("mid_reset_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("mid_reset_rsp_v", rsp_v_o, 0);
    chk("mid_reset_counts", {wr_count_o, rd_count_o}, 0);
    exp_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    b_cfg_q.delete(); r_cfg_q.delete();
    mon_wr = 0; mon_rd = 0; aw_delay = 0; w_delay = 0;
    @(negedge clk);
    reset_i = 0;
    aw0 = aw_cnt; w0 = w_cnt;
    send(1, 32'h0000_0044, 32'h0BAD_CAFE, 4'hC, 2'b00, 32'h0);
    wait_drain("post_reset");
    chk("post_reset_aw_beats", aw_cnt - aw0, 1);
    chk("post_reset_w_beats", w_cnt - w0, 1);
    chk_counts("post_reset");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
